// File: rtl/seg_scan_ctrl.sv
// rtl/seg_scan_ctrl.sv - 4-digit multiplexed 7-segment scan controller with frame snapshot and ghost blanking
module seg_scan_ctrl #(
    parameter int REFRESH_DIV = 100000,
    parameter int GHOST_CYC   = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] data_in,
    input  logic        blank_lz,
    output logic [3:0]  ENABLE,
    output logic [6:0]  LEDOUT,
    output logic        frame_done
);
    localparam int PW = $clog2(REFRESH_DIV);

    logic [PW-1:0] prescaler;
    logic [PW-1:0] pre_nxt;
    logic [1:0]    digit_idx;
    logic [1:0]    idx_nxt;
    logic [15:0]   snapshot;
    logic [15:0]   snap_nxt;
    logic          started;
    logic          started_nxt;
    logic          tick;
    logic          in_ghost;
    logic [3:0]    nibble;
    logic          lz_blank;
    logic [6:0]    seg;

    assign tick = (prescaler == PW'(REFRESH_DIV - 1));

    always_comb begin
        pre_nxt     = tick ? '0 : prescaler + 1'b1;
        idx_nxt     = digit_idx;
        snap_nxt    = snapshot;
        started_nxt = started | tick;
        if (tick) begin
            if (!started || digit_idx == 2'd3) begin
                idx_nxt  = 2'd0;
                snap_nxt = data_in;
            end else begin
                idx_nxt = digit_idx + 2'd1;
            end
        end
    end

    // Outputs are registered, so they are decoded from the state the next cycle will hold.
    if (GHOST_CYC == 0) begin : g_no_ghost
        assign in_ghost = 1'b0;
    end else begin : g_ghost
        assign in_ghost = (pre_nxt < PW'(GHOST_CYC));
    end

    assign nibble = 4'(snap_nxt >> {idx_nxt, 2'b00});

    always_comb begin
        lz_blank = 1'b0;
        case (idx_nxt)
            2'd1:    lz_blank = (snap_nxt[15:4] == 12'h000);
            2'd2:    lz_blank = (snap_nxt[15:8] == 8'h00);
            2'd3:    lz_blank = (snap_nxt[15:12] == 4'h0);
            default: lz_blank = 1'b0;
        endcase
        lz_blank = lz_blank & blank_lz;
    end

    always_comb begin
        seg = 7'b1111111;
        case (nibble)
            4'h0: seg = 7'b0000001;
            4'h1: seg = 7'b1001111;
            4'h2: seg = 7'b0010010;
            4'h3: seg = 7'b0000110;
            4'h4: seg = 7'b1001100;
            4'h5: seg = 7'b0100100;
            4'h6: seg = 7'b0100000;
            4'h7: seg = 7'b0001111;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0000100;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b1100000;
            4'hC: seg = 7'b0110001;
            4'hD: seg = 7'b1000010;
            4'hE: seg = 7'b0110000;
            4'hF: seg = 7'b0111000;
            default: seg = 7'b1111111;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prescaler  <= '0;
            digit_idx  <= 2'd0;
            snapshot   <= 16'h0000;
            started    <= 1'b0;
            ENABLE     <= 4'b1111;
            LEDOUT     <= 7'b1111111;
            frame_done <= 1'b0;
        end else begin
            prescaler  <= pre_nxt;
            digit_idx  <= idx_nxt;
            snapshot   <= snap_nxt;
            started    <= started_nxt;
            frame_done <= tick && started && (digit_idx == 2'd3);
            if (!started_nxt || in_ghost) begin
                ENABLE <= 4'b1111;
                LEDOUT <= 7'b1111111;
            end else begin
                ENABLE <= ~(4'b0001 << idx_nxt);
                LEDOUT <= lz_blank ? 7'b1111111 : seg;
            end
        end
    end
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb/tb_seg_scan_ctrl.sv - self-checking bench for seg_scan_ctrl against a cycle-count display model
module tb_seg_scan_ctrl;
    localparam int DIV = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] data_in;
    logic        blank_lz;
    logic [3:0]  en_a, en_b;
    logic [6:0]  led_a, led_b;
    logic        fd_a, fd_b;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    seg_scan_ctrl #(.REFRESH_DIV(DIV), .GHOST_CYC(2)) dut (
        .clk(clk), .reset(reset), .data_in(data_in), .blank_lz(blank_lz),
        .ENABLE(en_a), .LEDOUT(led_a), .frame_done(fd_a)
    );

    seg_scan_ctrl #(.REFRESH_DIV(DIV), .GHOST_CYC(0)) dut0 (
        .clk(clk), .reset(reset), .data_in(data_in), .blank_lz(blank_lz),
        .ENABLE(en_b), .LEDOUT(led_b), .frame_done(fd_b)
    );

    logic [6:0] seg_tab [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                                 7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                                 7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                                 7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

    // Model: time since reset release decides slot/digit; snapshot taken at each frame start.
    int          m_t = 0;
    logic [15:0] m_snap = 16'h0000;
    logic        m_lz = 1'b0;
    logic        m_valid = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            m_t = 0;
            m_snap = 16'h0000;
        end else begin
            m_t = m_t + 1;
            if (m_t >= DIV && ((m_t - DIV) % (4 * DIV)) == 0)
                m_snap = data_in;
        end
        m_lz = blank_lz;
        m_valid = 1'b1;
    end

    task automatic model_out(input int g, output logic [3:0] en, output logic [6:0] led,
                             output logic fd);
        int s, pos, d;
        logic [3:0] nib;
        logic [15:0] upper;
        en = 4'b1111; led = 7'b1111111; fd = 1'b0;
        if (m_t >= DIV) begin
            s = m_t - DIV;
            pos = s % DIV;
            d = (s / DIV) % 4;
            fd = (m_t >= 5 * DIV) && ((s % (4 * DIV)) == 0);
            if (pos >= g) begin
                en = ~(4'b0001 << d);
                upper = m_snap >> (4 * d);
                nib = upper[3:0];
                if (m_lz && d > 0 && upper == 16'h0000) led = 7'b1111111;
                else led = seg_tab[nib];
            end
        end
    endtask

    always @(negedge clk) begin
        logic [3:0] e; logic [6:0] l; logic f;
        if (m_valid) begin
            model_out(2, e, l, f);
            checks++;
            if (en_a !== e || led_a !== l || fd_a !== f) begin
                errors++;
                $display("FAIL model_g2 t=%0d got en=%b led=%b fd=%b want en=%b led=%b fd=%b",
                         m_t, en_a, led_a, fd_a, e, l, f);
            end
            model_out(0, e, l, f);
            checks++;
            if (en_b !== e || led_b !== l || fd_b !== f) begin
                errors++;
                $display("FAIL model_g0 t=%0d got en=%b led=%b fd=%b want en=%b led=%b fd=%b",
                         m_t, en_b, led_b, fd_b, e, l, f);
            end
        end
    end

    task automatic wait_t(input int target);
        int n = 0;
        while (m_t != target && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (m_t != target) begin
            errors++;
            $display("FAIL timeout waiting t=%0d got t=%0d", target, m_t);
        end
    endtask

    // Literal expectations pin both the DUT and the model at chosen instants.
    task automatic lit(input string name, input int g, input logic [3:0] en,
                       input logic [6:0] led, input logic fd);
        logic [3:0] me; logic [6:0] ml; logic mf;
        logic [3:0] de; logic [6:0] dl; logic df;
        if (g == 0) begin de = en_b; dl = led_b; df = fd_b; end
        else begin de = en_a; dl = led_a; df = fd_a; end
        model_out(g, me, ml, mf);
        checks++;
        if (de !== en || dl !== led || df !== fd) begin
            errors++;
            $display("FAIL %s dut en=%b led=%b fd=%b want en=%b led=%b fd=%b",
                     name, de, dl, df, en, led, fd);
        end
        checks++;
        if (me !== en || ml !== led || mf !== fd) begin
            errors++;
            $display("FAIL %s_model en=%b led=%b fd=%b want en=%b led=%b fd=%b",
                     name, me, ml, mf, en, led, fd);
        end
    endtask

    initial begin
        reset = 1'b1; data_in = 16'h1234; blank_lz = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        lit("reset_state", 2, 4'b1111, 7'b1111111, 1'b0);
        wait_t(7);   lit("idle_end", 2, 4'b1111, 7'b1111111, 1'b0);
        wait_t(8);   lit("ghost_d0", 2, 4'b1111, 7'b1111111, 1'b0);
        lit("noghost_d0", 0, 4'b1110, 7'b1001100, 1'b0);
        wait_t(10);  lit("d0_4", 2, 4'b1110, 7'b1001100, 1'b0);
        wait_t(18);  lit("d1_3", 2, 4'b1101, 7'b0000110, 1'b0);
        wait_t(20);  data_in = 16'hABCD;
        wait_t(26);  lit("d2_2", 2, 4'b1011, 7'b0010010, 1'b0);
        wait_t(34);  lit("d3_1", 2, 4'b0111, 7'b1001111, 1'b0);
        wait_t(39);  lit("pre_fd", 2, 4'b0111, 7'b1001111, 1'b0);
        wait_t(40);  lit("fd_pulse", 2, 4'b1111, 7'b1111111, 1'b1);
        wait_t(41);  lit("fd_gone", 2, 4'b1111, 7'b1111111, 1'b0);
        wait_t(42);  lit("f2_d0_D", 2, 4'b1110, 7'b1000010, 1'b0);
        wait_t(50);  lit("f2_d1_C", 2, 4'b1101, 7'b0110001, 1'b0);
        wait_t(58);  lit("f2_d2_b", 2, 4'b1011, 7'b1100000, 1'b0);
        wait_t(66);  lit("f2_d3_A", 2, 4'b0111, 7'b0001000, 1'b0);
        wait_t(67);  data_in = 16'h0050; blank_lz = 1'b1;
        wait_t(74);  lit("lz_d0_0", 2, 4'b1110, 7'b0000001, 1'b0);
        wait_t(82);  lit("lz_d1_5", 2, 4'b1101, 7'b0100100, 1'b0);
        wait_t(90);  lit("lz_d2_off", 2, 4'b1011, 7'b1111111, 1'b0);
        wait_t(98);  lit("lz_d3_off", 2, 4'b0111, 7'b1111111, 1'b0);
        wait_t(100); data_in = 16'h0000;
        wait_t(106); lit("zero_d0", 2, 4'b1110, 7'b0000001, 1'b0);
        wait_t(114); lit("zero_d1_off", 2, 4'b1101, 7'b1111111, 1'b0);
        wait_t(116); blank_lz = 1'b0;
        wait_t(122); lit("lz_live_d2", 2, 4'b1011, 7'b0000001, 1'b0);
        wait_t(154); data_in = 16'h5A3C; reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        lit("midreset", 2, 4'b1111, 7'b1111111, 1'b0);
        wait_t(7);   lit("post_rst_idle", 2, 4'b1111, 7'b1111111, 1'b0);
        wait_t(8);   lit("post_rst_g0", 0, 4'b1110, 7'b0110001, 1'b0);
        wait_t(10);  lit("post_rst_d0", 2, 4'b1110, 7'b0110001, 1'b0);
        wait_t(18);  lit("post_rst_d1", 2, 4'b1101, 7'b0000110, 1'b0);
        wait_t(45);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
- Display scan scheduler for the 4-digit, common-anode 7-segment display driven by the top-level processor module.
- Time-multiplexes one 16-bit value, the selected processor result, across four digits, one hex nibble per digit.
- Snapshots the value once per frame so the display never tears.
- Inserts an all-off ghost-blanking gap at every digit change and pulses frame_done at the end of each full frame.

Parameters:
- REFRESH_DIV, 100000: clock cycles per digit slot; minimum 4.
- GHOST_CYC, 2: cycles at the start of each slot during which ENABLE is all-off; 0 disables the gap; must be < REFRESH_DIV.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- data_in  input  16  value to display; sampled only at frame start.
- blank_lz  input  1  1 = blank leading-zero digits.
- ENABLE  output  4  digit anode enables, active-low; ENABLE[0] is the rightmost digit and shows data_in[3:0].
- LEDOUT  output  7  segments, active-low; LEDOUT[6]=a down to LEDOUT[0]=g.
- frame_done  output  1  one-cycle pulse when digit 3's slot ends.

Behaviour:
- All outputs are registered.
- Reset values:
  - ENABLE=4'b1111, LEDOUT=7'b1111111, frame_done=0.
  - Prescaler=0, digit_idx=0, snapshot=16'h0000, started=0.
- Prescaler:
  - Counts 0..REFRESH_DIV-1, then wraps to 0.
  - tick is asserted when prescaler==REFRESH_DIV-1.
  - Counter width is $clog2(REFRESH_DIV).
- Idle after reset: outputs stay blank until the first tick, which occurs REFRESH_DIV cycles after reset deasserts.
- On tick:
  - If started==0 or digit_idx==3: digit_idx<=0, snapshot<=data_in, started<=1.
  - Otherwise: digit_idx<=digit_idx+1.
  - frame_done<=1 only when started==1 and digit_idx==3. It is 0 on the first tick after reset and 0 on every non-tick cycle.
- Slot timing:
  - A slot runs from one tick edge to the next, i.e. REFRESH_DIV cycles.
  - The first GHOST_CYC cycles of each slot: ENABLE=4'b1111, LEDOUT=7'b1111111.
  - The remaining cycles: ENABLE=~(4'b0001<<digit_idx), LEDOUT=decode(nibble digit_idx of snapshot).
- Decode, active-low {a..g}:
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110
  - 4=1001100, 5=0100100, 6=0100000, 7=0001111
  - 8=0000000, 9=0000100, A=0001000, b=1100000
  - C=0110001, d=1000010, E=0110000, F=0111000
- Leading-zero blanking (blank_lz=1):
  - Digit k (k=1..3) is blank when snapshot nibbles k..3 are all zero.
  - A blank digit has its anode enabled per the schedule but LEDOUT=7'b1111111.
  - Digit 0 is never blanked.
  - blank_lz is read live each cycle, not snapshotted.
- data_in changes mid-frame have no effect until the next frame start.
- Reset mid-frame: all state returns to reset values on that edge. No frame_done is emitted. Outputs stay blank for REFRESH_DIV cycles.
- The scan is free-running with no handshake. frame_done is informational, e.g. for single-step display synchronisation.

Test Plan:
1. REFRESH_DIV=8, GHOST_CYC=2, data_in=16'h1234, blank_lz=0, reset for 3 cycles.
   - Outputs are blank for 8 cycles.
   - Then slot 0: 2 cycles all-off, then 6 cycles ENABLE=1110, LEDOUT=1001100 ("4").
   - Then digits 1..3 show 0000110, 0010010, 1001111 with ENABLE 1101, 1011, 0111.
2. Same configuration, continuous run.
   - frame_done pulses exactly 1 cycle, on the tick ending digit 3.
   - Period is 32 cycles.
   - No pulse on the first tick after reset.
3. Change data_in from 16'h1234 to 16'hABCD during digit 1's slot.
   - Digits 2 and 3 still show "2" and "1".
   - The next frame shows D, C, b, A: 1000010, 0110001, 1100000, 0001000.
4. blank_lz=1, data_in=16'h0050.
   - Digit 0 shows "0" (0000001) and digit 1 shows "5" (0100100).
   - Digits 2 and 3 give LEDOUT=1111111 with anodes still sequenced.
   - With data_in=16'h0000, only digit 0 lights.
5. GHOST_CYC=0: each slot drives its digit from the cycle after the tick, with no all-off gap.
6. Assert reset for 1 cycle during digit 2's slot.
   - Next cycle: ENABLE=1111, LEDOUT=1111111, frame_done=0.
   - Scan restarts at digit 0 after 8 cycles with a fresh snapshot.
